result_writeback: RTL
=====================

Name: result_writeback

Overview:
- Output stage directly downstream of the convolution datapath.
- On a start pulse, snapshots every PE's 4-byte result vector plus the 8-bit output base address (the Z pointer).
- Drains the snapshot one byte per accepted transfer into the output write memory, using a valid/ready handshake.
- Signals completion to the controller so the datapath can advance to the next window.

Parameters:
N, 4, number of PEs (filters); result vectors captured per start.
ADDR_W, 8, output memory address width; matches Z pointer width.
FILTER_STRIDE, 4, address distance between consecutive PE result groups.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  capture request; honoured only in IDLE.
res_in  input  8 x [0:N-1][0:3]  PE result bytes (PE index, byte index).
base_addr  input  ADDR_W  output base address, sampled with start.
mem_ready  input  1  write memory accepts the current byte this cycle.
mem_we  output  1  write valid.
mem_addr  output  ADDR_W  write address.
mem_wdata  output  8  write data.
busy  output  1  high while state is not IDLE.
done  output  1  one-cycle completion pulse.

Behaviour:
- rst low (async): state=IDLE.
  - mem_we, mem_addr, mem_wdata, busy, done all 0.
  - Holding registers and the pe/byte counters cleared.
  - Effect is immediate, including mid-burst; no further writes are issued.
- All outputs are registered.
- States: IDLE, WRITE, DONE.
- IDLE -> WRITE on the edge that samples start=1:
  - Latch res_in into hold[N][4] and base_addr into base_r.
  - pe=0, byte=0.
  - Same edge drives mem_we=1, mem_addr=base_addr, mem_wdata=res_in[0][0], busy=1.
- WRITE, handshake:
  - A transfer is accepted on an edge where mem_we=1 and mem_ready=1.
  - Without acceptance, mem_we/mem_addr/mem_wdata hold stable; there is no timeout.
- WRITE, sequencing:
  - On acceptance, byte increments. On byte wrap 3->0, pe increments.
  - Next outputs: mem_addr = base_r + pe*FILTER_STRIDE + byte, truncated mod 2^ADDR_W (wrap-around allowed, no error flag); mem_wdata = hold[pe][byte].
  - Order is PE0 bytes 0..3, PE1 bytes 0..3, ..., PE(N-1) byte 3.
- WRITE -> DONE on acceptance of the last byte (pe=N-1, byte=3):
  - Same edge drives mem_we=0, done=1.
- DONE -> IDLE unconditionally next edge: done=0, busy=0.
  - done is high exactly one cycle; busy is high from the cycle after start through the DONE cycle inclusive.
- start in WRITE or DONE is ignored (not queued).
  - start may be re-asserted in the first IDLE cycle.
- res_in/base_addr changes after capture do not affect the burst.
- Timing with mem_ready tied high:
  - Writes occupy N*4 consecutive cycles.
  - done occurs N*4 cycles after the capture edge.
  - Minimum start-to-start period is N*4+2 cycles.
- Counter widths: byte 2 bits, pe $clog2(N) bits (min 1).
- Address arithmetic is done at ADDR_W+$clog2(N)+2 bits, then truncated.

Test Plan:
1. Reset: assert rst=0 with random inputs -> all outputs 0; after release with start=0 for 10 cycles -> no mem_we.
2. Nominal burst (N=4, mem_ready=1):
   - Stimulus: base_addr=0x10, res_in[p][b]=16*p+b, start pulse.
   - Expect: 16 writes, addr 0x10..0x1F, data 0x00..0x33 in order; done pulse 16 cycles after capture edge; busy low next cycle.
3. Backpressure:
   - Stimulus: mem_ready pattern 1,0,0,1,0,1... throughout the burst.
   - Expect: addr/data stable while mem_ready=0; exactly 16 acceptances with no skipped or duplicated bytes; done 1 cycle after 16th acceptance.
4. Wrap and stride:
   - Stimulus: FILTER_STRIDE=64, base_addr=0xF0.
   - Expect: PE0 at 0xF0..0xF3, PE1 at 0x30..0x33, PE2 at 0x70..0x73, PE3 at 0xB0..0xB3.
5. Ignored start / input isolation:
   - Stimulus: pulse start again at write #5; change res_in and base_addr after capture.
   - Expect: burst unaffected, still 16 writes with original data, no second burst.
6. Reset mid-operation:
   - Stimulus: rst=0 after 5 accepted writes.
   - Expect: mem_we=0 asynchronously, busy=0, no done pulse.
   - After release, new start with base_addr=0x40 -> full fresh burst from 0x40 with PE0 byte0.

Source files
------------

// File: rtl/result_writeback_if.sv
// result_writeback_if
//   Byte-wide write bus between the result writeback stage and the output
//   write memory. Valid/ready handshake: a byte moves on a rising edge where
//   mem_we and mem_ready are both high.
//
//   Signals:
//     mem_we    - write valid (driven by master)
//     mem_addr  - write address, ADDR_W bits (driven by master)
//     mem_wdata - write data byte (driven by master)
//     mem_ready - memory accepts the current byte (driven by slave)
//
//   Modports: master (writeback stage), slave (memory side).

interface result_writeback_if #(
    parameter int ADDR_W = 8
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/result_writeback.sv
// result_writeback
//   Output stage behind the convolution datapath. A start pulse in IDLE
//   snapshots all N PE result vectors (4 bytes each) and the output base
//   address, then drains the snapshot one byte per accepted transfer to the
//   output write memory: PE0 bytes 0..3, PE1 bytes 0..3, ... Byte (pe, b)
//   goes to base + pe*FILTER_STRIDE + b, truncated to ADDR_W bits.
//   A one-cycle done pulse follows acceptance of the last byte.
//
//   Ports:
//     clk       - system clock, rising edge
//     rst       - asynchronous active-low reset
//     start     - capture request, honoured only in IDLE
//     res_in    - PE result bytes, indexed [pe][byte]
//     base_addr - output base address, sampled with start
//     wr        - write bus (master side: mem_we/mem_addr/mem_wdata/mem_ready)
//     busy      - high while not IDLE
//     done      - one-cycle completion pulse
//   All outputs are registered.

module result_writeback #(
    parameter int N             = 4,
    parameter int ADDR_W        = 8,
    parameter int FILTER_STRIDE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [0:N-1][0:3][7:0] res_in,
    input  logic [ADDR_W-1:0]      base_addr,
    result_writeback_if.master     wr,
    output logic                   busy,
    output logic                   done
);

    localparam int PE_W    = (N > 1) ? $clog2(N) : 1;
    localparam int AW_FULL = ADDR_W + PE_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t                 r_state;
    logic [0:N-1][0:3][7:0] r_hold;
    logic [ADDR_W-1:0]      r_base;
    logic [PE_W-1:0]        r_pe;
    logic [1:0]             r_byte;
    logic                   r_we;
    logic [ADDR_W-1:0]      r_addr;
    logic [7:0]             r_wdata;
    logic                   r_busy;
    logic                   r_done;

    state_t                 w_state_nxt;
    logic [0:N-1][0:3][7:0] w_hold_nxt;
    logic [ADDR_W-1:0]      w_base_nxt;
    logic [PE_W-1:0]        w_pe_nxt;
    logic [1:0]             w_byte_nxt;
    logic                   w_we_nxt;
    logic [ADDR_W-1:0]      w_addr_nxt;
    logic [7:0]             w_wdata_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;

    logic                   w_accept;
    logic                   w_last;
    logic [PE_W-1:0]        w_pe_inc;
    logic [1:0]             w_byte_inc;
    logic [AW_FULL-1:0]     w_addr_calc;

    assign w_accept   = r_we & wr.mem_ready;
    assign w_last     = (r_pe == PE_W'(N - 1)) && (r_byte == 2'd3);
    // Byte counter wraps 3->0 naturally; PE advances on that wrap.
    assign w_byte_inc = r_byte + 2'd1;
    assign w_pe_inc   = (r_byte == 2'd3) ? (r_pe + PE_W'(1)) : r_pe;
    // Computed wide so the stride product never overflows before the
    // deliberate truncation to ADDR_W.
    assign w_addr_calc = AW_FULL'(r_base)
                       + AW_FULL'(w_pe_inc) * AW_FULL'(FILTER_STRIDE)
                       + AW_FULL'(w_byte_inc);

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_base_nxt  = r_base;
        w_pe_nxt    = r_pe;
        w_byte_nxt  = r_byte;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_we_nxt   = 1'b0;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = WRITE;
                    w_hold_nxt  = res_in;
                    w_base_nxt  = base_addr;
                    w_pe_nxt    = '0;
                    w_byte_nxt  = '0;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = base_addr;
                    w_wdata_nxt = res_in[0][0];
                    w_busy_nxt  = 1'b1;
                end
            end
            WRITE: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                        w_we_nxt    = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_pe_nxt    = w_pe_inc;
                        w_byte_nxt  = w_byte_inc;
                        w_addr_nxt  = ADDR_W'(w_addr_calc);
                        w_wdata_nxt = r_hold[w_pe_inc][w_byte_inc];
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_we_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_we_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_base  <= '0;
            r_pe    <= '0;
            r_byte  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_base  <= w_base_nxt;
            r_pe    <= w_pe_nxt;
            r_byte  <= w_byte_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign wr.mem_we    = r_we;
    assign wr.mem_addr  = r_addr;
    assign wr.mem_wdata = r_wdata;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
